eth_rx_frame_buffer: RTL and testbench



---
 rtl/eth_rx_frame_buffer_if.sv | 25 ++
 rtl/eth_rx_frame_buffer.sv | 271 +++++++++++++++++++++++++++
 tb/tb_eth_rx_frame_buffer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/eth_rx_frame_buffer_if.sv
// Output stream of eth_rx_frame_buffer: show-ahead payload words with a
// valid/ready handshake, the frame ID, and first/last word markers.
//   master : producer (the frame buffer) drives valid/data/frameid/first/last
//   slave  : consumer drives out_ready
interface eth_rx_frame_buffer_if #(
  parameter int unsigned PAYLOAD_BITS = 148,
  parameter int unsigned ID_BYTES     = 3
);
  logic                    out_valid;
  logic                    out_ready;
  logic [PAYLOAD_BITS-1:0] out_data;
  logic [8*ID_BYTES-1:0]   out_frameid;
  logic                    out_first;
  logic                    out_last;

  modport master (
    output out_valid, out_data, out_frameid, out_first, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_frameid, out_first, out_last,
    output out_ready
  );
endinterface

// File: rtl/eth_rx_frame_buffer.sv
// MII receive frame parser with a multi-frame payload buffer.
// Finds preamble/SFD, filters on destination MAC, captures the frame ID and a
// fixed-length payload cut into WORDS words of PAYLOAD_BITS bits, and stores up
// to BUF_FRAMES committed frames that are read out word-by-word.
// Ports:
//   phy_rxclk, rst          : clock, synchronous active-high reset
//   phy_rxd/rxen/rxer       : MII receive nibble, data valid, error
//   out_if (master)         : out_valid/out_ready/out_data/out_frameid/out_first/out_last
//   frames_avail            : committed unread frames
//   drop_cnt, frame_err     : saturating dropped-frame count, one-cycle drop pulse
// Optional: define RX_CRC_CHECK_EN to verify the FCS before committing.
module eth_rx_frame_buffer #(
  parameter logic [47:0] MAC_ADDR     = 48'h0100_0000_0000,
  parameter int unsigned ID_BYTES     = 3,
  parameter int unsigned PAYLOAD_BITS = 148,
  parameter int unsigned WORDS        = 8,
  parameter int unsigned BUF_FRAMES   = 2
) (
  input  logic                            phy_rxclk,
  input  logic                            rst,
  input  logic [3:0]                      phy_rxd,
  input  logic                            phy_rxen,
  input  logic                            phy_rxer,
  eth_rx_frame_buffer_if.master           out_if,
  output logic [$clog2(BUF_FRAMES+1)-1:0] frames_avail,
  output logic [7:0]                      drop_cnt,
  output logic                            frame_err
);

  localparam int unsigned HDR_NIBS = 2 * (14 + ID_BYTES);
  localparam int unsigned PAY_NIBS = WORDS * PAYLOAD_BITS / 4;
  localparam int unsigned MAX_NIBS = (HDR_NIBS > PAY_NIBS) ? HDR_NIBS : PAY_NIBS;
  localparam int unsigned ID_START = 28;
  localparam int unsigned CNT_W    = $clog2(MAX_NIBS);
  localparam int unsigned BIT_W    = $clog2(PAYLOAD_BITS);
  localparam int unsigned WORD_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned SLOT_W   = (BUF_FRAMES > 1) ? $clog2(BUF_FRAMES) : 1;
  localparam int unsigned AVL_W    = $clog2(BUF_FRAMES + 1);
  localparam int unsigned ID_W     = 8 * ID_BYTES;

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_HEADER, S_PAYLOAD, S_FCS, S_DONE, S_DROP
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [3:0]              prev_nib_q, prev_nib_d;
  logic                    rxen_prev_q, rxen_prev_d;
  logic [47:0]             dest_q, dest_d;
  logic [ID_W-1:0]         id_asm_q, id_asm_d;
  logic [PAYLOAD_BITS-1:0] asm_q, asm_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [WORD_W-1:0]       wr_word_q, wr_word_d, rd_word_q, rd_word_d;
  logic [SLOT_W-1:0]       wr_slot_q, wr_slot_d, rd_slot_q, rd_slot_d;
  logic [AVL_W-1:0]        avail_q, avail_d;
  logic [7:0]              drop_cnt_q, drop_cnt_d;
  logic                    frame_err_q, frame_err_d;

  logic [PAYLOAD_BITS-1:0] mem_q [BUF_FRAMES][WORDS];
  logic [ID_W-1:0]         id_q  [BUF_FRAMES];

  logic                    wr_en, commit, drop_evt, rd_fire, rd_release, crc_ok;
  logic [PAYLOAD_BITS-1:0] wr_data;
  logic [3:0]              nib_sh;

`ifdef RX_CRC_CHECK_EN
  // Register runs reflected (LSB-first); the good-frame residue in that form
  // is the bit-reverse of the conventional 0xC704DD7B constant.
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;
  logic [31:0] crc_q, crc_d, crc_rev;

  function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] n);
    logic [31:0] r;
    r = c;
    for (int unsigned i = 0; i < 4; i++) begin
      if (r[0] ^ n[i]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  assign crc_rev = {<<{crc_q}};
  assign crc_ok  = (crc_rev == CRC_RESIDUE);
`else
  assign crc_ok = 1'b1;
`endif

  assign rd_fire    = (avail_q != '0) && out_if.out_ready;
  assign rd_release = rd_fire && (rd_word_q == WORD_W'(WORDS - 1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    prev_nib_d  = prev_nib_q;
    rxen_prev_d = phy_rxen;
    dest_d      = dest_q;
    id_asm_d    = id_asm_q;
    asm_d       = asm_q;
    bit_d       = bit_q;
    wr_word_d   = wr_word_q;
    wr_slot_d   = wr_slot_q;
    rd_word_d   = rd_word_q;
    rd_slot_d   = rd_slot_q;
    avail_d     = avail_q;
    wr_en       = 1'b0;
    wr_data     = asm_q;
    commit      = 1'b0;
    drop_evt    = 1'b0;
    nib_sh      = phy_rxd;
`ifdef RX_CRC_CHECK_EN
    crc_d = crc_q;
    if (phy_rxen && (state_q == S_HEADER || state_q == S_PAYLOAD || state_q == S_FCS))
      crc_d = crc_nib(crc_q, phy_rxd);
`endif

    if (phy_rxen) prev_nib_d = phy_rxd;

    if (!phy_rxen) begin
      case (state_q)
        S_PREAMBLE, S_HEADER, S_PAYLOAD, S_FCS: drop_evt = 1'b1;
        S_DONE: if (crc_ok) commit = 1'b1; else drop_evt = 1'b1;
        default: ;
      endcase
      state_d = S_IDLE;
    end else begin
      case (state_q)
        // Only a genuine rxen rising edge starts a frame, so a frame still in
        // flight when reset releases is ignored rather than re-parsed.
        S_IDLE: if (!rxen_prev_q) state_d = S_PREAMBLE;
        S_PREAMBLE: begin
          if (phy_rxd == 4'hD && prev_nib_q == 4'h5) begin
            if (avail_q == AVL_W'(BUF_FRAMES)) begin
              state_d  = S_DROP;
              drop_evt = 1'b1;
            end else begin
              state_d   = S_HEADER;
              cnt_d     = '0;
              bit_d     = '0;
              wr_word_d = '0;
`ifdef RX_CRC_CHECK_EN
              crc_d = '1;
`endif
            end
          end
        end
        S_HEADER, S_PAYLOAD, S_FCS, S_DONE: begin
          if (phy_rxer || state_q == S_DONE) begin
            state_d  = S_DROP;
            drop_evt = 1'b1;
          end else if (state_q == S_HEADER) begin
            if (cnt_q < CNT_W'(12)) dest_d = {phy_rxd, dest_q[47:4]};
            if (cnt_q >= CNT_W'(ID_START)) id_asm_d = {phy_rxd, id_asm_q[ID_W-1:4]};
            if (cnt_q == CNT_W'(11) && {phy_rxd, dest_q[47:4]} != MAC_ADDR) begin
              state_d = S_DROP;  // not for us: silent
            end else if (cnt_q == CNT_W'(HDR_NIBS - 1)) begin
              state_d = S_PAYLOAD;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else if (state_q == S_PAYLOAD) begin
            // Bit-serial assembly so a word boundary may fall inside a nibble.
            for (int unsigned i = 0; i < 4; i++) begin
              asm_d  = {nib_sh[0], asm_d[PAYLOAD_BITS-1:1]};
              nib_sh = nib_sh >> 1;
              if (bit_d == BIT_W'(PAYLOAD_BITS - 1)) begin
                wr_en   = 1'b1;
                wr_data = asm_d;
                bit_d   = '0;
              end else begin
                bit_d = bit_d + 1'b1;
              end
            end
            if (wr_en) wr_word_d = wr_word_q + 1'b1;
            if (cnt_q == CNT_W'(PAY_NIBS - 1)) begin
              state_d = S_FCS;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            if (cnt_q == CNT_W'(7)) state_d = S_DONE;
            else                    cnt_d   = cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (commit)
      wr_slot_d = (wr_slot_q == SLOT_W'(BUF_FRAMES - 1)) ? '0 : wr_slot_q + 1'b1;

    if (rd_fire) begin
      if (rd_release) begin
        rd_word_d = '0;
        rd_slot_d = (rd_slot_q == SLOT_W'(BUF_FRAMES - 1)) ? '0 : rd_slot_q + 1'b1;
      end else begin
        rd_word_d = rd_word_q + 1'b1;
      end
    end

    case ({commit, rd_release})
      2'b10:   avail_d = avail_q + 1'b1;
      2'b01:   avail_d = avail_q - 1'b1;
      default: avail_d = avail_q;
    endcase

    drop_cnt_d  = (drop_evt && drop_cnt_q != 8'hFF) ? drop_cnt_q + 1'b1 : drop_cnt_q;
    frame_err_d = drop_evt;
  end

  always_ff @(posedge phy_rxclk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      prev_nib_q  <= '0;
      rxen_prev_q <= 1'b1;
      dest_q      <= '0;
      id_asm_q    <= '0;
      asm_q       <= '0;
      bit_q       <= '0;
      wr_word_q   <= '0;
      wr_slot_q   <= '0;
      rd_word_q   <= '0;
      rd_slot_q   <= '0;
      avail_q     <= '0;
      drop_cnt_q  <= '0;
      frame_err_q <= 1'b0;
`ifdef RX_CRC_CHECK_EN
      crc_q       <= '1;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prev_nib_q  <= prev_nib_d;
      rxen_prev_q <= rxen_prev_d;
      dest_q      <= dest_d;
      id_asm_q    <= id_asm_d;
      asm_q       <= asm_d;
      bit_q       <= bit_d;
      wr_word_q   <= wr_word_d;
      wr_slot_q   <= wr_slot_d;
      rd_word_q   <= rd_word_d;
      rd_slot_q   <= rd_slot_d;
      avail_q     <= avail_d;
      drop_cnt_q  <= drop_cnt_d;
      frame_err_q <= frame_err_d;
`ifdef RX_CRC_CHECK_EN
      crc_q       <= crc_d;
`endif
    end
  end

  // Storage is not reset; slot validity is carried by avail_q alone.
  always_ff @(posedge phy_rxclk) begin
    if (wr_en)  mem_q[wr_slot_q][wr_word_q] <= wr_data;
    if (commit) id_q[wr_slot_q]             <= id_asm_q;
  end

  // Data fields are forced to zero while nothing is available.
  assign out_if.out_valid   = (avail_q != '0);
  assign out_if.out_data    = out_if.out_valid ? mem_q[rd_slot_q][rd_word_q] : '0;
  assign out_if.out_frameid = out_if.out_valid ? id_q[rd_slot_q] : '0;
  assign out_if.out_first   = out_if.out_valid && (rd_word_q == '0);
  assign out_if.out_last    = out_if.out_valid && (rd_word_q == WORD_W'(WORDS - 1));

  assign frames_avail = avail_q;
  assign drop_cnt     = drop_cnt_q;
  assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_eth_rx_frame_buffer.sv
// Directed bench for eth_rx_frame_buffer: builds complete MII frames
// (preamble, SFD, header, ID, payload, CRC-32 FCS) and checks commit timing,
// read-out order/contents, drop counting and reset behaviour.
module tb_eth_rx_frame_buffer;

  localparam int unsigned PB     = 148;
  localparam int unsigned WORDS  = 8;
  localparam int unsigned IDB    = 3;
  localparam int unsigned BUFN   = 2;
  localparam int unsigned PBYTES = WORDS * PB / 8;
  localparam logic [47:0] MAC    = 48'h0100_0000_0000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] rxd = '0;
  logic       rxen = 1'b0;
  logic       rxer = 1'b0;
  logic [1:0] frames_avail;
  logic [7:0] drop_cnt;
  logic       frame_err;

  eth_rx_frame_buffer_if #(.PAYLOAD_BITS(PB), .ID_BYTES(IDB)) sif ();

  eth_rx_frame_buffer #(
    .MAC_ADDR(MAC), .ID_BYTES(IDB), .PAYLOAD_BITS(PB), .WORDS(WORDS), .BUF_FRAMES(BUFN)
  ) dut (
    .phy_rxclk(clk), .rst(rst), .phy_rxd(rxd), .phy_rxen(rxen), .phy_rxer(rxer),
    .out_if(sif.master), .frames_avail(frames_avail), .drop_cnt(drop_cnt),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned err_pulses = 0;
  int unsigned p0;
  logic [7:0]  frm[$];

  always @(negedge clk) if (frame_err === 1'b1) err_pulses++;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pay_byte(input int unsigned seed, input int unsigned k);
    return 8'((k + seed * 37) & 255);
  endfunction

  // len_adj: -1 drops the last byte, +1 appends one; corrupt flips an FCS bit.
  task automatic build_frame(input logic [47:0] dest, input logic [23:0] id,
                             input int unsigned seed, input int len_adj, input bit corrupt);
    logic [7:0]  body[$];
    logic [31:0] crc;
    frm.delete();
    repeat (7) frm.push_back(8'h55);
    frm.push_back(8'hD5);
    for (int unsigned k = 0; k < 6; k++) body.push_back(dest[8*k +: 8]);
    for (int unsigned k = 0; k < 6; k++) body.push_back(8'(8'h10 + k));
    body.push_back(8'h88);
    body.push_back(8'hB5);
    for (int unsigned k = 0; k < IDB; k++) body.push_back(id[8*k +: 8]);
    for (int unsigned k = 0; k < PBYTES; k++) body.push_back(pay_byte(seed, k));
    crc = '1;
    foreach (body[j]) begin
      crc = crc ^ {24'h0, body[j]};
      repeat (8) crc = crc[0] ? ((crc >> 1) ^ 32'hEDB88320) : (crc >> 1);
    end
    crc = ~crc;
    if (corrupt) crc = crc ^ 32'h0000_0100;
    for (int unsigned k = 0; k < 4; k++) body.push_back(crc[8*k +: 8]);
    if (len_adj < 0) void'(body.pop_back());
    if (len_adj > 0) body.push_back(8'h00);
    foreach (body[j]) frm.push_back(body[j]);
  endtask

  task automatic send_nibs(input int unsigned n, input int err_at);
    logic [7:0] b;
    for (int unsigned i = 0; i < n; i++) begin
      tick();
      b    = frm[i / 2];
      rxen = 1'b1;
      rxd  = i[0] ? b[7:4] : b[3:0];
      rxer = (int'(i) == err_at);
    end
  endtask

  task automatic end_frame(input logic rdy);
    tick();
    rxen          = 1'b0;
    rxer          = 1'b0;
    sif.out_ready = rdy;
  endtask

  task automatic send_full(input int err_at);
    send_nibs(2 * frm.size(), err_at);
    end_frame(1'b0);
    tick();
    tick();
  endtask

  task automatic drain(input int unsigned nfr, input logic [23:0] id0, input int unsigned s0,
                       input logic [23:0] id1, input int unsigned s1);
    logic [PB*WORDS-1:0] pv;
    int unsigned w, total, f, wi;
    w     = 0;
    total = nfr * WORDS;
    sif.out_ready = 1'b1;
    for (int unsigned cyc = 0; cyc < 400 && w < total; cyc++) begin
      if (sif.out_valid) begin
        f  = w / WORDS;
        wi = w % WORDS;
        for (int unsigned k = 0; k < PBYTES; k++) pv[8*k +: 8] = pay_byte((f == 0) ? s0 : s1, k);
        check("word_data", sif.out_data, pv[PB*wi +: PB]);
        check("word_first", sif.out_first, wi == 0);
        check("word_last", sif.out_last, wi == WORDS - 1);
        check("word_id", sif.out_frameid, (f == 0) ? id0 : id1);
        w++;
      end
      tick();
    end
    sif.out_ready = 1'b0;
    check("drain_words", w, total);
  endtask

  initial begin
    sif.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_valid", sif.out_valid, 1'b0);
    check("rst_avail", frames_avail, 2'd0);
    check("rst_drop_cnt", drop_cnt, 8'd0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_data", sif.out_data, '0);
    check("rst_first", sif.out_first, 1'b0);

    // Single good frame, consumer always ready.
    build_frame(MAC, 24'h123456, 0, 0, 1'b0);
    sif.out_ready = 1'b1;
    send_nibs(2 * frm.size(), -1);
    end_frame(1'b1);
    check("commit_not_early", frames_avail, 2'd0);
    tick();
    check("commit_latency", frames_avail, 2'd1);
    drain(1, 24'h123456, 0, 24'h0, 0);
    check("t1_empty", frames_avail, 2'd0);

    // Three frames with consumer stalled: third finds the buffer full.
    p0 = err_pulses;
    build_frame(MAC, 24'hA1A2A3, 1, 0, 1'b0); send_full(-1);
    build_frame(MAC, 24'hB1B2B3, 2, 0, 1'b0); send_full(-1);
    build_frame(MAC, 24'hC1C2C3, 3, 0, 1'b0); send_full(-1);
    check("full_avail", frames_avail, 2'd2);
    check("full_drop_cnt", drop_cnt, 8'd1);
    check("full_err_pulse", err_pulses - p0, 1);
    drain(2, 24'hA1A2A3, 1, 24'hB1B2B3, 2);
    check("full_empty", frames_avail, 2'd0);

    // Foreign destination is dropped silently; rxer mid-payload is counted.
    p0 = err_pulses;
    build_frame(48'h0200_0000_0000, 24'h0D0D0D, 4, 0, 1'b0); send_full(-1);
    check("dest_avail", frames_avail, 2'd0);
    check("dest_drop_cnt", drop_cnt, 8'd1);
    check("dest_no_pulse", err_pulses - p0, 0);
    build_frame(MAC, 24'h0E0E0E, 5, 0, 1'b0); send_full(120);
    check("rxer_drop_cnt", drop_cnt, 8'd2);
    check("rxer_avail", frames_avail, 2'd0);
    check("rxer_pulse", err_pulses - p0, 1);

    // One byte short, one byte long.
    build_frame(MAC, 24'h0F0F0F, 6, -1, 1'b0); send_full(-1);
    build_frame(MAC, 24'h101010, 7, 1, 1'b0); send_full(-1);
    check("len_drop_cnt", drop_cnt, 8'd4);
    check("len_avail", frames_avail, 2'd0);

    // Commit lands on the same edge as the final-word release of the previous frame.
    build_frame(MAC, 24'hAAAA01, 8, 0, 1'b0); send_full(-1);
    check("coin_pre_avail", frames_avail, 2'd1);
    sif.out_ready = 1'b1;
    repeat (7) tick();
    sif.out_ready = 1'b0;
    check("coin_at_last", sif.out_last, 1'b1);
    build_frame(MAC, 24'hBBBB02, 9, 0, 1'b0);
    send_nibs(2 * frm.size(), -1);
    end_frame(1'b1);
    tick();
    sif.out_ready = 1'b0;
    check("coin_avail", frames_avail, 2'd1);
    check("coin_first", sif.out_first, 1'b1);
    check("coin_id", sif.out_frameid, 24'hBBBB02);
    drain(1, 24'hBBBB02, 9, 24'h0, 0);
    check("coin_empty", frames_avail, 2'd0);

    // Reset mid-payload with rxen held high, including SFD-like nibbles afterwards.
    build_frame(MAC, 24'hDEAD01, 10, 0, 1'b0);
    send_nibs(100, -1);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int unsigned i = 0; i < 6; i++) begin
      tick();
      rxd = i[0] ? 4'hD : 4'h5;
    end
    end_frame(1'b0);
    tick();
    tick();
    check("rst_mid_avail", frames_avail, 2'd0);
    check("rst_mid_drop_cnt", drop_cnt, 8'd0);
    check("rst_mid_valid", sif.out_valid, 1'b0);
    build_frame(MAC, 24'h777777, 11, 0, 1'b0); send_full(-1);
    check("post_rst_avail", frames_avail, 2'd1);
    drain(1, 24'h777777, 11, 24'h0, 0);
    check("post_rst_drop_cnt", drop_cnt, 8'd0);

`ifdef RX_CRC_CHECK_EN
    build_frame(MAC, 24'hC0C0C0, 12, 0, 1'b1); send_full(-1);
    check("crc_drop_cnt", drop_cnt, 8'd1);
    check("crc_avail", frames_avail, 2'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
